// File: rtl/cnt_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnt_uart_pkg
// Brief    : Shared frame constants and FSM state encoding for cnt_uart_tx.
// Revision : 1.0
// ============================================================================
package cnt_uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/cnt_uart_baud.sv
`default_nettype none
// ============================================================================
// Module   : cnt_uart_baud
// Brief    : Bit-period counter; one-cycle o_tick every CLKS_PER_BIT enabled
//            cycles, restarted by i_clear at frame start.
// Revision : 1.0
// ============================================================================
module cnt_uart_baud #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_en,
   output logic o_tick
);

   localparam int              W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [W-1:0]    c_TERM = W'(CLKS_PER_BIT - 1);

   logic [W-1:0] r_cnt;
   logic         w_term;

   assign w_term = (r_cnt == c_TERM);
   assign o_tick = i_en && !i_clear && w_term;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clear || !i_en || w_term) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/cnt_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : cnt_uart_tx
// Brief    : Byte-wide UART transmitter (LSB first, 1 or 2 stop bits).
//            Define CNT_UART_TX_PARITY_EN to add an even-parity bit.
// Revision : 1.0
// ============================================================================
module cnt_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       ready_out,
   output logic       tx_out,
   output logic       busy_out
);
   import cnt_uart_pkg::*;

   localparam logic [2:0] c_LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic       c_LAST_STOP = (STOP_BITS == 2);

   state_t     r_state;
   logic [7:0] r_shift;
   logic [2:0] r_idx;
   logic       r_stop_idx;
   logic       r_tx;
   logic       r_armed;
`ifdef CNT_UART_TX_PARITY_EN
   logic       r_par;
`endif

   logic       w_accept;
   logic       w_tick;

   // r_armed keeps ready_out low until the first edge after reset release.
   assign ready_out = r_armed && (r_state == ST_IDLE);
   assign busy_out  = (r_state != ST_IDLE);
   assign tx_out    = r_tx;
   assign w_accept  = ready_out && valid_in;

   cnt_uart_baud #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk     (clk),
      .rst     (rst),
      .i_clear (w_accept),
      .i_en    (busy_out),
      .o_tick  (w_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_shift    <= '0;
         r_idx      <= '0;
         r_stop_idx <= 1'b0;
         r_tx       <= 1'b1;
         r_armed    <= 1'b0;
`ifdef CNT_UART_TX_PARITY_EN
         r_par      <= 1'b0;
`endif
      end else begin
         r_armed <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_shift <= data_in;
                  r_tx    <= 1'b0;
                  r_state <= ST_START;
`ifdef CNT_UART_TX_PARITY_EN
                  r_par   <= ^data_in;
`endif
               end
            end
            ST_START: begin
               if (w_tick) begin
                  r_tx    <= r_shift[0];
                  r_shift <= r_shift >> 1;
                  r_state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_tick) begin
                  r_idx <= r_idx + 3'd1;
                  if (r_idx == c_LAST_BIT) begin
`ifdef CNT_UART_TX_PARITY_EN
                     r_tx    <= r_par;
                     r_state <= ST_PARITY;
`else
                     r_tx    <= 1'b1;
                     r_state <= ST_STOP;
`endif
                  end else begin
                     r_tx    <= r_shift[0];
                     r_shift <= r_shift >> 1;
                  end
               end
            end
`ifdef CNT_UART_TX_PARITY_EN
            ST_PARITY: begin
               if (w_tick) begin
                  r_tx    <= 1'b1;
                  r_state <= ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               if (w_tick) begin
                  if (r_stop_idx == c_LAST_STOP) begin
                     r_stop_idx <= 1'b0;
                     r_state    <= ST_IDLE;
                  end else begin
                     r_stop_idx <= r_stop_idx + 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cnt_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_cnt_uart_tx
// Brief    : Self-checking bench for cnt_uart_tx (scoreboard + serial monitor).
// Revision : 1.0
// ============================================================================
module tb_cnt_uart_tx;

   localparam int CPB  = 4;
   localparam int CPB2 = 2;
`ifdef CNT_UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       valid_in = 1'b0;
   logic       ready_out, tx_out, busy_out;
   logic [7:0] d2_data = 8'h00;
   logic       d2_valid = 1'b0;
   logic       d2_ready, d2_tx, d2_busy;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   int         rx_t[$];
   logic       rx_p[$];
   int         mon_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cnt_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
      .ready_out(ready_out), .tx_out(tx_out), .busy_out(busy_out)
   );

   cnt_uart_tx #(.CLKS_PER_BIT(CPB2), .STOP_BITS(2)) dut2 (
      .clk(clk), .rst(rst), .data_in(d2_data), .valid_in(d2_valid),
      .ready_out(d2_ready), .tx_out(d2_tx), .busy_out(d2_busy)
   );

   // Serial-line receiver for dut: decodes frames sampled on falling edges.
   logic [7:0] m_b;
   logic       m_v, m_p;
   bit         m_ab;
   int         m_t0;
   always begin : p_mon
      @(negedge clk);
      if (!rst && tx_out === 1'b0) begin
         m_t0 = cyc; m_ab = 0; m_b = 8'h00; m_p = 1'b0;
         for (int i = 1; i < CPB; i++) begin
            @(negedge clk); if (rst) m_ab = 1;
            if (!m_ab && tx_out !== 1'b0) mon_bad++;
         end
         for (int k = 0; k < 8; k++) begin
            @(negedge clk); if (rst) m_ab = 1;
            m_v = tx_out;
            for (int i = 1; i < CPB; i++) begin
               @(negedge clk); if (rst) m_ab = 1;
               if (!m_ab && tx_out !== m_v) mon_bad++;
            end
            m_b[k] = m_v;
         end
`ifdef CNT_UART_TX_PARITY_EN
         @(negedge clk); if (rst) m_ab = 1;
         m_p = tx_out;
         for (int i = 1; i < CPB; i++) begin
            @(negedge clk); if (rst) m_ab = 1;
            if (!m_ab && tx_out !== m_p) mon_bad++;
         end
`endif
         for (int i = 0; i < CPB; i++) begin
            @(negedge clk); if (rst) m_ab = 1;
            if (!m_ab && tx_out !== 1'b1) mon_bad++;
         end
         if (!m_ab) begin
            rx_q.push_back(m_b);
            rx_t.push_back(m_t0);
            rx_p.push_back(m_p);
         end
      end
   end

   // Waits (caller at a falling edge, inputs set) for the accepting edge.
   task automatic accept(input logic [7:0] b, input bit push, output bit ok);
      ok = 0;
      for (int i = 0; i < 400; i++) begin
         if (ready_out === 1'b1) begin
            @(posedge clk);
            if (push) exp_q.push_back(b);
            ok = 1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_rx(input int n);
      for (int i = 0; i < 300 && rx_q.size() < n; i++) @(negedge clk);
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_checks++; if (tx_out !== 1'b1) begin n_err++; $display("FAIL rst_tx: got %b want 1", tx_out); end
      n_checks++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy_out); end
      n_checks++; if (ready_out !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", ready_out); end
      n_checks++; if (d2_tx !== 1'b1) begin n_err++; $display("FAIL rst_tx2: got %b want 1", d2_tx); end
      rst = 1'b0;
      #1;
      n_checks++; if (ready_out !== 1'b0) begin n_err++; $display("FAIL rst_ready_early: got %b want 0", ready_out); end
      @(posedge clk); #1;
      n_checks++; if (ready_out !== 1'b1) begin n_err++; $display("FAIL rst_ready_release: got %b want 1", ready_out); end
   endtask

   task automatic test_frame_a5;
      bit ok; int n; logic [7:0] got, want;
      @(negedge clk); data_in = 8'hA5; valid_in = 1'b1;
      accept(8'hA5, 1, ok);
      n_checks++; if (!ok) begin n_err++; $display("FAIL a5_accept: got timeout want accept"); end
      @(negedge clk); valid_in = 1'b0;
      n_checks++; if (tx_out !== 1'b0) begin n_err++; $display("FAIL a5_start_latency: got %b want 0", tx_out); end
      n_checks++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL a5_busy: got %b want 1", busy_out); end
      n = 0;
      for (int i = 0; i < 200 && ready_out !== 1'b1; i++) begin n++; @(negedge clk); end
      n_checks++; if (n != 40 + 4*P) begin n_err++; $display("FAIL a5_ready_low: got %0d want %0d", n, 40 + 4*P); end
      n_checks++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL a5_busy_end: got %b want 0", busy_out); end
      wait_rx(1);
      if (rx_q.size() == 0 || exp_q.size() == 0) begin
         n_checks++; n_err++; $display("FAIL a5_byte: got none want a5");
      end else begin
         got = rx_q.pop_front(); want = exp_q.pop_front(); void'(rx_t.pop_front()); void'(rx_p.pop_front());
         n_checks++; if (got !== want) begin n_err++; $display("FAIL a5_byte: got %h want %h", got, want); end
      end
      n_checks++; if (mon_bad != 0) begin n_err++; $display("FAIL a5_bit_hold: got %0d glitches want 0", mon_bad); end
   endtask

   task automatic test_back_to_back;
      bit ok0, ok1; logic [7:0] g0, g1, w0, w1; int t0, t1;
      @(negedge clk); data_in = 8'h00; valid_in = 1'b1;
      accept(8'h00, 1, ok0);
      @(negedge clk); data_in = 8'hFF;
      accept(8'hFF, 1, ok1);
      @(negedge clk); valid_in = 1'b0;
      n_checks++; if (!(ok0 && ok1)) begin n_err++; $display("FAIL b2b_accept: got %b%b want 11", ok0, ok1); end
      wait_rx(2);
      n_checks++;
      if (rx_q.size() != 2 || exp_q.size() != 2) begin
         n_err++; $display("FAIL b2b_count: got %0d frames want 2 (exp %0d)", rx_q.size(), exp_q.size());
      end else begin
         g0 = rx_q.pop_front(); g1 = rx_q.pop_front(); w0 = exp_q.pop_front(); w1 = exp_q.pop_front();
         t0 = rx_t.pop_front(); t1 = rx_t.pop_front(); void'(rx_p.pop_front()); void'(rx_p.pop_front());
         n_checks++; if (g0 !== w0) begin n_err++; $display("FAIL b2b_byte0: got %h want %h", g0, w0); end
         n_checks++; if (g1 !== w1) begin n_err++; $display("FAIL b2b_byte1: got %h want %h", g1, w1); end
         n_checks++; if (t1 - t0 != 41 + 4*P) begin n_err++; $display("FAIL b2b_spacing: got %0d want %0d", t1 - t0, 41 + 4*P); end
      end
      n_checks++; if (mon_bad != 0) begin n_err++; $display("FAIL b2b_bit_hold: got %0d glitches want 0", mon_bad); end
   endtask

   task automatic test_data_hold;
      bit ok; logic [7:0] got, want;
      @(negedge clk); data_in = 8'hC3; valid_in = 1'b1;
      accept(8'hC3, 1, ok);
      @(negedge clk); valid_in = 1'b0; data_in = 8'h3C;
      wait_rx(1);
      if (!ok || rx_q.size() == 0 || exp_q.size() == 0) begin
         n_checks++; n_err++; $display("FAIL hold_byte: got none want c3");
      end else begin
         got = rx_q.pop_front(); want = exp_q.pop_front(); void'(rx_t.pop_front()); void'(rx_p.pop_front());
         n_checks++; if (got !== want) begin n_err++; $display("FAIL hold_byte: got %h want %h", got, want); end
      end
   endtask

`ifdef CNT_UART_TX_PARITY_EN
   task automatic test_parity;
      bit ok; int n; logic [7:0] got, want, d; logic gp;
      d = 8'h07;
      @(negedge clk); data_in = d; valid_in = 1'b1;
      accept(d, 1, ok);
      @(negedge clk); valid_in = 1'b0;
      n = 0;
      for (int i = 0; i < 200 && ready_out !== 1'b1; i++) begin n++; @(negedge clk); end
      n_checks++; if (n != 44) begin n_err++; $display("FAIL par_frame_len: got %0d want 44", n); end
      wait_rx(1);
      if (!ok || rx_q.size() == 0 || exp_q.size() == 0) begin
         n_checks++; n_err++; $display("FAIL par_byte: got none want 07");
      end else begin
         got = rx_q.pop_front(); want = exp_q.pop_front(); void'(rx_t.pop_front()); gp = rx_p.pop_front();
         n_checks++; if (got !== want) begin n_err++; $display("FAIL par_byte: got %h want %h", got, want); end
         n_checks++; if (gp !== ^d) begin n_err++; $display("FAIL par_bit: got %b want %b", gp, ^d); end
      end
   endtask
`endif

   task automatic test_stop2;
      logic [7:0] d; logic s, e, rdy22; bit ok;
      d = 8'h80; ok = 0; rdy22 = 1'b0;
      @(negedge clk); d2_data = d; d2_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (d2_ready === 1'b1) begin @(posedge clk); ok = 1; break; end
         @(negedge clk);
      end
      n_checks++; if (!ok) begin n_err++; $display("FAIL stop2_accept: got timeout want accept"); end
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         s = d2_tx;
         if (i == 22) rdy22 = d2_ready;
         if (i < CPB2) e = 1'b0;
         else if (i < 9*CPB2) e = d[(i - CPB2) / CPB2];
         else if (i < 11*CPB2 + 1) e = 1'b1;
         else e = 1'b0;
         n_checks++; if (s !== e) begin n_err++; $display("FAIL stop2_tx[%0d]: got %b want %b", i, s, e); end
      end
      n_checks++; if (rdy22 !== 1'b1) begin n_err++; $display("FAIL stop2_ready: got %b want 1", rdy22); end
      d2_valid = 1'b0;
   endtask

   task automatic test_reset_mid;
      bit ok;
      @(negedge clk); data_in = 8'h5A; valid_in = 1'b1;
      accept(8'h5A, 0, ok);
      @(negedge clk); valid_in = 1'b0;
      repeat (12) @(negedge clk);
      n_checks++; if (busy_out !== 1'b1 || tx_out !== 1'b0) begin
         n_err++; $display("FAIL mid_pre: got busy=%b tx=%b want busy=1 tx=0", busy_out, tx_out);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++; if (tx_out !== 1'b1) begin n_err++; $display("FAIL mid_tx: got %b want 1", tx_out); end
      n_checks++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", busy_out); end
      n_checks++; if (ready_out !== 1'b0) begin n_err++; $display("FAIL mid_ready: got %b want 0", ready_out); end
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      #1;
      n_checks++; if (ready_out !== 1'b0) begin n_err++; $display("FAIL mid_ready_early: got %b want 0", ready_out); end
      @(posedge clk); #1;
      n_checks++; if (ready_out !== 1'b1) begin n_err++; $display("FAIL mid_ready_release: got %b want 1", ready_out); end
      repeat (60) @(negedge clk);
      n_checks++; if (rx_q.size() != 0 || tx_out !== 1'b1) begin
         n_err++; $display("FAIL mid_aborted: got %0d frames tx=%b want 0 frames tx=1", rx_q.size(), tx_out);
      end
   endtask

   initial begin
      test_reset;
      test_frame_a5;
      test_back_to_back;
      test_data_hold;
`ifdef CNT_UART_TX_PARITY_EN
      test_parity;
`endif
      test_stop2;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/cnt_uart_tx.md
CNT_UART_TX -- requirements
Module: cnt_uart_tx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, 16, clock cycles per serial bit (legal range 2..4095).
REQ-002 SHALL have parameter: STOP_BITS, 1, number of stop bits per frame (legal values 1 or 2).
REQ-003 SHALL have port: clk  input  1  single design clock; all state rising-edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: data_in  input  8  byte to transmit (the counter/mux byte from the top-level stage).
REQ-006 SHALL have port: valid_in  input  1  data_in is valid.
REQ-007 SHALL have port: ready_out  output  1  block can accept a byte this cycle.
REQ-008 SHALL have port: tx_out  output  1  serial line, idle high.
REQ-009 SHALL have port: busy_out  output  1  a frame is in progress.

Function
REQ-010 SHALL accept a byte on the rising clk edge where valid_in && ready_out, latching data_in into an internal shift register.
REQ-011 SHALL assert ready_out only in state IDLE, combinationally from state, with no dependence on valid_in.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY is reachable only per REQ-026.
REQ-013 SHALL transition IDLE->START on acceptance, START->DATA after CLKS_PER_BIT cycles, DATA->STOP (or PARITY) after 8 bits, STOP->IDLE after STOP_BITS*CLKS_PER_BIT cycles.
REQ-014 SHALL drive tx_out low starting the first cycle after the acceptance edge (latency 1 cycle).
REQ-015 SHALL send data LSB first, each bit held exactly CLKS_PER_BIT cycles; tx_out high during STOP.
REQ-016 SHALL give a frame period of (10 + STOP_BITS - 1) * CLKS_PER_BIT + 1 cycles for back-to-back transfers with valid_in held high (one IDLE cycle between frames).
REQ-017 SHALL ignore valid_in and data_in changes while not in IDLE; no byte is lost or duplicated.
REQ-018 SHALL assert busy_out in every state except IDLE.
REQ-019 SHALL size the bit-period counter as clog2(CLKS_PER_BIT) bits and the bit index as 3 bits; both wrap to 0 at their terminal counts.
REQ-020 SHALL drive tx_out from a register (glitch-free output).

Reset
REQ-021 SHALL, while rst is high, force state IDLE, tx_out=1, busy_out=0, ready_out=0, and counters/shift register to 0.
REQ-022 SHALL abort any frame in progress on rst assertion, with tx_out returning high asynchronously.
REQ-023 SHALL assert ready_out on the first clk edge after rst deasserts, and never earlier.

Configuration
REQ-024 SHALL use macro CNT_UART_TX_PARITY_EN to compile the parity feature in or out.
REQ-025 SHALL, without the macro, send 8N frames with no PARITY state logic present.
REQ-026 SHALL, with the macro, insert one even-parity bit (XOR of the 8 data bits) after bit 7 for CLKS_PER_BIT cycles, extending the frame period by CLKS_PER_BIT.

Structure
REQ-027 SHALL place the state enum typedef and the frame-length constants (DATA_BITS=8) in shared package cnt_uart_pkg.
REQ-028 SHALL use one sub-module, cnt_uart_baud, producing a one-cycle bit-tick pulse every CLKS_PER_BIT cycles, cleared on frame start.

Verification
REQ-029 SHALL verify with CLKS_PER_BIT=4 and data 0xA5: tx_out = 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles; ready_out low for 40 cycles.
REQ-030 SHALL verify with valid_in held high, bytes 0x00 then 0xFF: two frames with a 41-cycle start-to-start spacing and no lost byte.
REQ-031 SHALL verify that changing data_in to 0x3C during a frame of 0xC3 leaves the transmitted bits as 0xC3.
REQ-032 SHALL verify rst asserted mid-DATA: tx_out=1 immediately, busy_out=0, and ready_out=1 one edge after release.
REQ-033 SHALL verify with CNT_UART_TX_PARITY_EN, data 0x07: parity bit 1 appears after bit 7, and the frame is 44 cycles at CLKS_PER_BIT=4.
REQ-034 SHALL verify STOP_BITS=2, CLKS_PER_BIT=2, data 0x80: tx_out holds high 4 cycles after bit 7 before the next frame can start.
